mem_port_arbiter: RTL

//  Shares the single simple_memory request port between the fetch stage (I-port) and the

---
 rtl/mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory request port between the fetch (I) and load/store (D) paths.
// One access is outstanding at a time; D has priority, bounded by a streak limit.
module mem_port_arbiter #(
  parameter int D_STREAK_MAX = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        if_req_stb,
  input  logic [31:0] if_req_addr,
  input  logic        if_abort,
  output logic        if_busy,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  input  logic        d_req_stb,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_busy,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic        mem_req_stb,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_req_valid,
  input  logic [31:0] mem_req_data,
  output logic        o_bus_err
);

  localparam int SW = $clog2(D_STREAK_MAX + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_LIMIT = SW'(D_STREAK_MAX);
  localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_I,
    ST_WAIT_D
  } state_t;

  state_t        state_q, state_d;
  logic          i_slot_q, i_slot_d;
  logic [31:0]   i_addr_q, i_addr_d;
  logic          d_slot_q, d_slot_d;
  logic          d_we_q, d_we_d;
  logic [31:0]   d_addr_q, d_addr_d;
  logic [31:0]   d_wdata_q, d_wdata_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          discard_q, discard_d;
  logic          mem_stb_q, mem_stb_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          if_rv_q, if_rv_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          d_rv_q, d_rv_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          bus_err_q, bus_err_d;

  logic          rsp_done;
  logic          timed_out;
  logic [31:0]   rsp_data;

  assign rsp_done  = mem_req_valid || (timer_q == TIMER_LAST);
  assign timed_out = !mem_req_valid && (timer_q == TIMER_LAST);
  assign rsp_data  = mem_req_valid ? mem_req_data : 32'h0;

  always_comb begin
    state_d     = state_q;
    i_slot_d    = i_slot_q;
    i_addr_d    = i_addr_q;
    d_slot_d    = d_slot_q;
    d_we_d      = d_we_q;
    d_addr_d    = d_addr_q;
    d_wdata_d   = d_wdata_q;
    streak_d    = streak_q;
    timer_d     = timer_q;
    discard_d   = discard_q;
    mem_stb_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rv_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rv_d      = 1'b0;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = bus_err_q;

    // An abort on an issued fetch cannot recall the memory access, so its response is discarded.
    if (i_slot_q) begin
      if (if_abort) begin
        if (state_q == ST_WAIT_I) begin
          discard_d = 1'b1;
        end else begin
          i_slot_d = 1'b0;
        end
      end
    end else if (if_req_stb && !if_abort) begin
      i_slot_d = 1'b1;
      i_addr_d = if_req_addr;
    end

    if (!d_slot_q && d_req_stb) begin
      d_slot_d  = 1'b1;
      d_we_d    = d_req_we;
      d_addr_d  = d_req_addr;
      d_wdata_d = d_req_wdata;
    end

    // IDLE looks at the slot contents including this cycle's accepts, so a re-request races fairly.
    unique case (state_q)
      ST_IDLE: begin
        if (d_slot_d && (!i_slot_d || streak_q != STREAK_LIMIT)) begin
          mem_stb_d   = 1'b1;
          mem_we_d    = d_we_d;
          mem_addr_d  = d_addr_d;
          mem_wdata_d = d_wdata_d;
          timer_d     = '0;
          state_d     = ST_WAIT_D;
          streak_d    = i_slot_d ? streak_q + SW'(1) : '0;
        end else if (i_slot_d) begin
          mem_stb_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr_d;
          mem_wdata_d = 32'h0;
          timer_d     = '0;
          state_d     = ST_WAIT_I;
          streak_d    = '0;
        end
      end
      ST_WAIT_I: begin
        if (rsp_done) begin
          if (!discard_d) begin
            if_rv_d    = 1'b1;
            if_rdata_d = rsp_data;
          end
          i_slot_d  = 1'b0;
          discard_d = 1'b0;
          state_d   = ST_IDLE;
          if (timed_out) begin
            bus_err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_D: begin
        if (rsp_done) begin
          d_rv_d    = 1'b1;
          d_rdata_d = d_we_q ? 32'h0 : rsp_data;
          d_slot_d  = 1'b0;
          state_d   = ST_IDLE;
          if (timed_out) begin
            bus_err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!i_slot_d) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      i_slot_q    <= 1'b0;
      i_addr_q    <= 32'h0;
      d_slot_q    <= 1'b0;
      d_we_q      <= 1'b0;
      d_addr_q    <= 32'h0;
      d_wdata_q   <= 32'h0;
      streak_q    <= '0;
      timer_q     <= '0;
      discard_q   <= 1'b0;
      mem_stb_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_rv_q     <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rv_q      <= 1'b0;
      d_rdata_q   <= 32'h0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_slot_q    <= i_slot_d;
      i_addr_q    <= i_addr_d;
      d_slot_q    <= d_slot_d;
      d_we_q      <= d_we_d;
      d_addr_q    <= d_addr_d;
      d_wdata_q   <= d_wdata_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
      discard_q   <= discard_d;
      mem_stb_q   <= mem_stb_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rv_q     <= if_rv_d;
      if_rdata_q  <= if_rdata_d;
      d_rv_q      <= d_rv_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign if_busy       = i_slot_q;
  assign if_resp_valid = if_rv_q;
  assign if_resp_data  = if_rdata_q;
  assign d_busy        = d_slot_q;
  assign d_resp_valid  = d_rv_q;
  assign d_resp_data   = d_rdata_q;
  assign mem_req_stb   = mem_stb_q;
  assign mem_req_we    = mem_we_q;
  assign mem_req_addr  = mem_addr_q;
  assign mem_req_wdata = mem_wdata_q;
  assign o_bus_err     = bus_err_q;

endmodule
